div_seq: RTL

- Multi-cycle radix-2 restoring divider controller for the NPC execute stage.
- Sequences one shared add_with_Cout instance (subtract mode, Cin=1) over DATA_LEN iterations to produce quotient and remainder.
- Supports signed and unsigned operands with RISC-V M-extension corner-case results.
- Valid/ready handshake on both sides; accepts one operation at a time.

---
 rtl/div_seq.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider, signed/unsigned, RISC-V M corner-case results.
// Optional `DIV_EARLY_OUT_EN: skip iterations when the result is known at accept time.

module add_with_Cout #(
    parameter int W = 32
) (
    input  logic [W-1:0] OP_A,
    input  logic [W-1:0] OP_B,
    input  logic         Cin,
    output logic [W-1:0] Sum,
    output logic         Cout
);
    logic [W:0] w_full;

    assign w_full = {1'b0, OP_A} + {1'b0, OP_B} + {{W{1'b0}}, Cin};
    assign Sum    = w_full[W-1:0];
    assign Cout   = w_full[W];
endmodule

module div_seq #(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_signed,
    input  logic [DATA_LEN-1:0] in_dividend,
    input  logic [DATA_LEN-1:0] in_divisor,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_quotient,
    output logic [DATA_LEN-1:0] out_remainder,
    output logic                busy
);
    localparam int N     = DATA_LEN;
    localparam int CNT_W = $clog2(DATA_LEN) + 1;
    localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_rem;
    logic [N-1:0]     r_dvd;
    logic [N-1:0]     r_dvs;
    logic [N-1:0]     r_orig;
    logic             r_qsign;
    logic             r_rsign;
    logic             r_divz;
    logic             r_ovf;
    logic [N-1:0]     r_q;
    logic [N-1:0]     r_r;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [N-1:0]     w_abs_dvd;
    logic [N-1:0]     w_abs_dvs;
    logic             w_divz;
    logic             w_ovf;
    logic [N:0]       w_shift;
    logic [N-1:0]     w_sum;
    logic             w_cout;
    logic             w_no_borrow;
    logic [N-1:0]     w_q_fix;
    logic [N-1:0]     w_r_fix;

    assign w_dvd_neg = in_signed & in_dividend[N-1];
    assign w_dvs_neg = in_signed & in_divisor[N-1];
    assign w_abs_dvd = w_dvd_neg ? -in_dividend : in_dividend;
    assign w_abs_dvs = w_dvs_neg ? -in_divisor  : in_divisor;
    assign w_divz    = (in_divisor == '0);
    assign w_ovf     = in_signed & (in_dividend == MIN_VAL) & (&in_divisor);

    // Inverted divisor with Cin=1 turns the adder into a subtractor; a set top bit
    // of the shifted remainder means it already exceeds any N-bit divisor.
    assign w_shift = {r_rem, r_dvd[N-1]};

    add_with_Cout #(.W(N)) u_add (
        .OP_A (w_shift[N-1:0]),
        .OP_B (~r_dvs),
        .Cin  (1'b1),
        .Sum  (w_sum),
        .Cout (w_cout)
    );

    assign w_no_borrow = w_shift[N] | w_cout;

    assign w_q_fix = r_divz ? '1
                   : r_ovf  ? MIN_VAL
                   : (r_qsign ? -r_dvd : r_dvd);
    assign w_r_fix = r_divz ? r_orig
                   : r_ovf  ? '0
                   : (r_rsign ? -r_rem : r_rem);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_orig      <= '0;
            r_qsign     <= 1'b0;
            r_rsign     <= 1'b0;
            r_divz      <= 1'b0;
            r_ovf       <= 1'b0;
            r_q         <= '0;
            r_r         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_orig     <= in_dividend;
                        r_dvs      <= w_abs_dvs;
                        r_qsign    <= w_dvd_neg ^ w_dvs_neg;
                        r_rsign    <= w_dvd_neg;
                        r_divz     <= w_divz;
                        r_ovf      <= w_ovf;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
                        if (w_divz || w_ovf || (w_abs_dvd < w_abs_dvs)) begin
                            r_rem   <= w_abs_dvd;
                            r_dvd   <= '0;
                            r_state <= S_FIX;
                        end else begin
                            r_rem   <= '0;
                            r_dvd   <= w_abs_dvd;
                            r_state <= S_CALC;
                        end
`else
                        r_rem   <= '0;
                        r_dvd   <= w_abs_dvd;
                        r_state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    r_rem <= w_no_borrow ? w_sum : w_shift[N-1:0];
                    r_dvd <= {r_dvd[N-2:0], w_no_borrow};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(N-1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_q         <= w_q_fix;
                    r_r         <= w_r_fix;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign busy          = r_busy;
    assign out_quotient  = r_q;
    assign out_remainder = r_r;
endmodule
